// File: rtl/filt_peak_detect.sv
// -----------------------------------------------------------------------------
// filt_peak_detect
//
// Purpose:
//   Finds peaks in a smoothed, unsigned sample stream. An event starts when
//   a sample rises above the threshold. The event ends at the first sample at
//   or below the threshold. The largest sample of the event and its sample
//   index are then reported with a one-cycle pulse. After each report, a
//   fixed number of samples is ignored before a new event can start.
//
// Parameters:
//   DATA_WIDTH  - width of data_in, thresh and peak_value (unsigned)
//   IDX_WIDTH   - width of the free-running sample index and peak_index
//   HOLDOFF_LEN - samples ignored after each report (0..255)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   ena        in   sample strobe; data_in/thresh are used only when high
//   data_in    in   smoothed sample
//   thresh     in   live detection threshold
//   peak_valid out  one-cycle pulse marking a reported peak
//   peak_value out  maximum of the last reported event (held)
//   peak_index out  sample index of peak_value (held)
//   busy       out  high while an event is armed or in holdoff
// -----------------------------------------------------------------------------
module filt_peak_detect #(
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_WIDTH   = 16,
    parameter int HOLDOFF_LEN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] thresh,
    output logic                  peak_valid,
    output logic [DATA_WIDTH-1:0] peak_value,
    output logic [IDX_WIDTH-1:0]  peak_index,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF_LEN);

    state_t                state, state_nxt;
    logic [IDX_WIDTH-1:0]  idx, idx_nxt;
    logic [7:0]            hold_cnt, hold_nxt;
    logic [DATA_WIDTH-1:0] max_val, max_nxt;
    logic [IDX_WIDTH-1:0]  max_idx, max_idx_nxt;
    logic                  pv_nxt;
    logic [DATA_WIDTH-1:0] pval_nxt;
    logic [IDX_WIDTH-1:0]  pidx_nxt;

    // State register. Reset wins over ena and discards any event in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            hold_cnt   <= '0;
            max_val    <= '0;
            max_idx    <= '0;
            peak_valid <= 1'b0;
            peak_value <= '0;
            peak_index <= '0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            hold_cnt   <= hold_nxt;
            max_val    <= max_nxt;
            max_idx    <= max_idx_nxt;
            peak_valid <= pv_nxt;
            peak_value <= pval_nxt;
            peak_index <= pidx_nxt;
        end
    end

    // Next-state logic. Everything holds unless ena is high. The peak_valid
    // pulse defaults to 0, so it lasts exactly one clk cycle.
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        hold_nxt    = hold_cnt;
        max_nxt     = max_val;
        max_idx_nxt = max_idx;
        pv_nxt      = 1'b0;
        pval_nxt    = peak_value;
        pidx_nxt    = peak_index;

        if (ena) begin
            // The index counter wraps naturally, so an event can span the wrap.
            idx_nxt = idx + IDX_WIDTH'(1);
            case (state)
                IDLE: begin
                    if (data_in > thresh) begin
                        state_nxt   = ARMED;
                        max_nxt     = data_in;
                        max_idx_nxt = idx;
                    end
                end
                ARMED: begin
                    // Test the falling condition first. The sample that ends
                    // the event never updates the max, even if thresh has
                    // moved above it.
                    if (data_in <= thresh) begin
                        pv_nxt    = 1'b1;
                        pval_nxt  = max_val;
                        pidx_nxt  = max_idx;
                        hold_nxt  = HOLD_LOAD;
                        state_nxt = (HOLDOFF_LEN == 0) ? IDLE : HOLDOFF;
                    end else if (data_in > max_val) begin
                        max_nxt     = data_in;
                        max_idx_nxt = idx;
                    end
                end
                HOLDOFF: begin
                    // The last ignored sample is the one that takes the
                    // counter from 1 to 0.
                    hold_nxt = hold_cnt - 8'd1;
                    if (hold_cnt <= 8'd1) begin
                        hold_nxt  = 8'd0;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign busy = (state == ARMED) || (state == HOLDOFF);

endmodule

// File: tb/tb_filt_peak_detect.sv
// -----------------------------------------------------------------------------
// tb_filt_peak_detect
//
// Purpose:
//   Directed self-checking bench for filt_peak_detect. Three instances share
//   the same stimulus:
//     dut    - default parameters (HOLDOFF_LEN = 4)
//     dut_h0 - HOLDOFF_LEN = 0
//     dut_w4 - IDX_WIDTH = 4, used for the index wrap case
// -----------------------------------------------------------------------------
module tb_filt_peak_detect;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ena = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] thresh = '0;

    logic        pv, busy;
    logic [15:0] pval, pidx;
    logic        pv_h0, busy_h0;
    logic [15:0] pval_h0, pidx_h0;
    logic        pv_w4, busy_w4;
    logic [15:0] pval_w4;
    logic [3:0]  pidx_w4;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    filt_peak_detect dut (
        .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .thresh(thresh),
        .peak_valid(pv), .peak_value(pval), .peak_index(pidx), .busy(busy)
    );

    filt_peak_detect #(.HOLDOFF_LEN(0)) dut_h0 (
        .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .thresh(thresh),
        .peak_valid(pv_h0), .peak_value(pval_h0), .peak_index(pidx_h0), .busy(busy_h0)
    );

    filt_peak_detect #(.IDX_WIDTH(4)) dut_w4 (
        .clk(clk), .rst(rst), .ena(ena), .data_in(data_in), .thresh(thresh),
        .peak_valid(pv_w4), .peak_value(pval_w4), .peak_index(pidx_w4), .busy(busy_w4)
    );

    // Drive one cycle at the falling edge. Return #1 after the rising edge
    // that samples it, when the outputs are stable.
    task automatic do_cycle(input logic e, input logic [15:0] d);
        @(negedge clk);
        ena     = e;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ena = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst     = 1'b1;
        ena     = 1'b1;
        thresh  = 16'd100;
        data_in = 16'd500;
        @(posedge clk);
        #1;
        tests_run++;
        if (pv !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got=%0d exp=0", pv); end
        tests_run++;
        if (pval !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_value got=%0d exp=0", pval); end
        tests_run++;
        if (pidx !== 16'd0) begin tests_failed++; $display("[TB] FAIL reset_index got=%0d exp=0", pidx); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got=%0d exp=0", busy); end
        @(negedge clk);
        rst = 1'b0;
        ena = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        thresh = 16'd100;
        do_cycle(1'b1, 16'd50);
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_idle_busy got=%0d exp=0", busy); end
        do_cycle(1'b1, 16'd120);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_armed_busy got=%0d exp=1", busy); end
        do_cycle(1'b1, 16'd180);
        do_cycle(1'b1, 16'd150);
        tests_run++;
        if (pv !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_early_valid got=%0d exp=0", pv); end
        do_cycle(1'b1, 16'd90);
        tests_run++;
        if (pv !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_valid got=%0d exp=1", pv); end
        tests_run++;
        if (pval !== 16'd180) begin tests_failed++; $display("[TB] FAIL basic_value got=%0d exp=180", pval); end
        tests_run++;
        if (pidx !== 16'd2) begin tests_failed++; $display("[TB] FAIL basic_index got=%0d exp=2", pidx); end
        do_cycle(1'b1, 16'd50);
        tests_run++;
        if (pv !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_pulse_width got=%0d exp=0", pv); end
        tests_run++;
        if (pval !== 16'd180) begin tests_failed++; $display("[TB] FAIL basic_value_held got=%0d exp=180", pval); end
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_holdoff_busy got=%0d exp=1", busy); end
    endtask

    task automatic test_tie();
        do_reset();
        thresh = 16'd100;
        do_cycle(1'b1, 16'd150);
        do_cycle(1'b1, 16'd150);
        do_cycle(1'b1, 16'd80);
        tests_run++;
        if (pv !== 1'b1) begin tests_failed++; $display("[TB] FAIL tie_valid got=%0d exp=1", pv); end
        tests_run++;
        if (pval !== 16'd150) begin tests_failed++; $display("[TB] FAIL tie_value got=%0d exp=150", pval); end
        tests_run++;
        if (pidx !== 16'd0) begin tests_failed++; $display("[TB] FAIL tie_index got=%0d exp=0", pidx); end
    endtask

    task automatic test_holdoff();
        do_reset();
        thresh = 16'd100;
        do_cycle(1'b1, 16'd150);
        do_cycle(1'b1, 16'd50);
        tests_run++;
        if (pv !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_first_valid got=%0d exp=1", pv); end
        tests_run++;
        if (pv_h0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL h0_first_valid got=%0d exp=1", pv_h0); end
        tests_run++;
        if (busy_h0 !== 1'b0) begin tests_failed++; $display("[TB] FAIL h0_idle_after_peak got=%0d exp=0", busy_h0); end
        for (int i = 0; i < 4; i++) begin
            do_cycle(1'b1, 16'd200);
            if (i == 0) begin
                tests_run++;
                if (busy_h0 !== 1'b1) begin tests_failed++; $display("[TB] FAIL h0_rearm got=%0d exp=1", busy_h0); end
            end
            if (i < 3) begin
                tests_run++;
                if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_busy_%0d got=%0d exp=1", i, busy); end
            end
        end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_ended got=%0d exp=0", busy); end
        do_cycle(1'b1, 16'd200);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_fifth_rearm got=%0d exp=1", busy); end
        do_cycle(1'b1, 16'd50);
        tests_run++;
        if (pv !== 1'b1 || pval !== 16'd200 || pidx !== 16'd6) begin
            tests_failed++;
            $display("[TB] FAIL hold_second_peak got=%0d/%0d/%0d exp=1/200/6", pv, pval, pidx);
        end
        tests_run++;
        if (pv_h0 !== 1'b1 || pval_h0 !== 16'd200 || pidx_h0 !== 16'd2) begin
            tests_failed++;
            $display("[TB] FAIL h0_second_peak got=%0d/%0d/%0d exp=1/200/2", pv_h0, pval_h0, pidx_h0);
        end
    endtask

    task automatic test_reset_armed();
        do_reset();
        thresh = 16'd100;
        do_cycle(1'b1, 16'd50);
        do_cycle(1'b1, 16'd150);
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstarm_armed got=%0d exp=1", busy); end
        @(negedge clk);
        rst     = 1'b1;
        ena     = 1'b1;
        data_in = 16'd60;
        @(posedge clk);
        #1;
        tests_run++;
        if (pv !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstarm_no_pulse got=%0d exp=0", pv); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstarm_busy got=%0d exp=0", busy); end
        @(negedge clk);
        rst = 1'b0;
        ena = 1'b0;
        do_cycle(1'b1, 16'd170);
        do_cycle(1'b1, 16'd40);
        tests_run++;
        if (pv !== 1'b1 || pval !== 16'd170 || pidx !== 16'd0) begin
            tests_failed++;
            $display("[TB] FAIL rstarm_fresh got=%0d/%0d/%0d exp=1/170/0", pv, pval, pidx);
        end
    endtask

    task automatic test_ena_gap();
        logic [15:0] samples [5];
        samples = '{16'd50, 16'd120, 16'd180, 16'd150, 16'd90};
        do_reset();
        thresh = 16'd100;
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b0, 16'd999);
            do_cycle(1'b0, 16'd5);
            tests_run++;
            if (pv !== 1'b0) begin tests_failed++; $display("[TB] FAIL gap_idle_valid_%0d got=%0d exp=0", i, pv); end
            do_cycle(1'b1, samples[i]);
        end
        tests_run++;
        if (pv !== 1'b1 || pval !== 16'd180 || pidx !== 16'd2) begin
            tests_failed++;
            $display("[TB] FAIL gap_peak got=%0d/%0d/%0d exp=1/180/2", pv, pval, pidx);
        end
        do_cycle(1'b0, 16'd999);
        tests_run++;
        if (pv !== 1'b0) begin tests_failed++; $display("[TB] FAIL gap_pulse_width got=%0d exp=0", pv); end
    endtask

    task automatic test_wrap();
        do_reset();
        thresh = 16'd100;
        for (int i = 0; i < 14; i++) do_cycle(1'b1, 16'd0);
        do_cycle(1'b1, 16'd150);
        do_cycle(1'b1, 16'd200);
        do_cycle(1'b1, 16'd250);
        tests_run++;
        if (pv_w4 !== 1'b0 || busy_w4 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wrap_span got=%0d/%0d exp=0/1", pv_w4, busy_w4);
        end
        do_cycle(1'b1, 16'd255);
        do_cycle(1'b1, 16'd50);
        tests_run++;
        if (pv_w4 !== 1'b1 || pval_w4 !== 16'd255 || pidx_w4 !== 4'd1) begin
            tests_failed++;
            $display("[TB] FAIL wrap_peak got=%0d/%0d/%0d exp=1/255/1", pv_w4, pval_w4, pidx_w4);
        end
        do_cycle(1'b1, 16'd50);
        tests_run++;
        if (pv_w4 !== 1'b0) begin tests_failed++; $display("[TB] FAIL wrap_pulse_width got=%0d exp=0", pv_w4); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie();
        test_holdoff();
        test_reset_armed();
        test_ena_gap();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/filt_peak_detect.md
FILT_PEAK_DETECT -- requirements
Module: filt_peak_detect

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the sample width (unsigned) of data_in, thresh and peak_value.
REQ-002 Parameter IDX_WIDTH, default 16, SHALL set the width of the sample index counter and peak_index.
REQ-003 Parameter HOLDOFF_LEN, default 4, range 0..255, SHALL set the number of enabled samples ignored after each reported peak.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 ena  input  1  sample strobe, active-high; data_in and thresh SHALL be sampled only when high (fed by the boxcar filter's enable-aligned avg_out).
REQ-007 data_in  input  DATA_WIDTH  smoothed sample from the upstream moving-average filter.
REQ-008 thresh  input  DATA_WIDTH  detection threshold, live, sampled on each ena cycle.
REQ-009 peak_valid  output  1  one-cycle registered pulse marking a reported peak.
REQ-010 peak_value  output  DATA_WIDTH  maximum sample of the last reported event; held until the next report.
REQ-011 peak_index  output  IDX_WIDTH  sample index of peak_value; held until the next report.
REQ-012 busy  output  1  high while in state ARMED or HOLDOFF.

Function
REQ-013 The index counter SHALL increment by 1 on every ena cycle and wrap from 2^IDX_WIDTH-1 to 0 without flagging.
REQ-014 The FSM SHALL have states IDLE, ARMED and HOLDOFF; the state, index counter and holdoff counter SHALL change only on ena cycles.
REQ-015 IDLE: on ena with data_in > thresh (strict), go to ARMED and capture max = data_in, max_idx = current index.
REQ-016 ARMED: on ena with data_in > max (strict), update max and max_idx; on a tie, keep the first occurrence.
REQ-017 ARMED: on ena with data_in <= thresh, copy max/max_idx to peak_value/peak_index, pulse peak_valid, load the holdoff counter with HOLDOFF_LEN, and go to HOLDOFF; if HOLDOFF_LEN = 0, go to IDLE instead.
REQ-018 The falling sample in REQ-017 SHALL NOT update max, even if it exceeds max (impossible while thresh is constant, defined for a changing thresh).
REQ-019 HOLDOFF: samples SHALL be ignored; the counter SHALL decrement on each ena; on the ena cycle where it reaches 0, go to IDLE, so exactly HOLDOFF_LEN samples are ignored.
REQ-020 Latency: peak_valid, peak_value and peak_index SHALL be updated at the clock edge that samples the falling ena cycle, visible one cycle later; peak_valid SHALL be high for exactly one clk cycle, even if ena stays high.
REQ-021 With ena low, peak_valid SHALL be 0 and all other state SHALL hold.
REQ-022 An event still in ARMED SHALL span index wrap-around unaffected; peak_index SHALL report the raw wrapped index.

Reset
REQ-023 rst SHALL force state IDLE, index counter 0, holdoff counter 0, max 0, max_idx 0, peak_valid 0, peak_value 0, peak_index 0 and busy 0 at the next edge, with priority over ena.
REQ-024 A reset while in ARMED or HOLDOFF SHALL discard the event with no peak_valid pulse.

Structure
REQ-025 No shared package SHALL be used; the three state encodings SHALL be local constants of the module.
REQ-026 The module SHALL be self-contained with no sub-module; the holdoff counter width SHALL be 8 bits.

Verification
REQ-027 Threshold 100, ena held high, samples 50,120,180,150,90 -> one peak_valid pulse with peak_value=180 and peak_index=2, one cycle after the sample 90 is taken.
REQ-028 Tie case: threshold 100, samples 150,150,80 -> peak_value=150, peak_index=first-150 index.
REQ-029 HOLDOFF_LEN=4: after a peak, 4 samples of 200 are ignored and the fifth re-arms; test with HOLDOFF_LEN=0 re-arms on the next sample.
REQ-030 Assert rst in ARMED -> no pulse; busy=0 and index=0 on the next cycle; fresh detection afterwards works.
REQ-031 ena toggling 1-of-3 cycles during an event -> same peak_value and peak_index as with ena held high; peak_valid width is 1 clk.
REQ-032 IDX_WIDTH=4: event arming at index 14 and peaking at index 1 -> peak_index=1, peak_valid pulse unaffected.
